noc_traffic_harness: RTL

NOC_TRAFFIC_HARNESS -- requirements
Module: noc_traffic_harness

---
 rtl/noc_traffic_harness.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/noc_traffic_harness.sv
// Traffic harness for a NoC DUT. It replays a flit stream from a packet memory into the DUT,
// throttles each sink with a periodic ready pattern, tallies sink traffic and flags deadlock.
module noc_traffic_harness #(
    parameter int  DW    = 32,
    parameter int  NSINK = 2,
    parameter int  DEPTH = 1024,
    parameter int  WIN   = 10000,
    parameter int  DRAIN = 50000,
    parameter int  CW    = 32,
    localparam int AW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [DW-1:0]         cfg_data,
    input  logic [AW-1:0]         pkt_cnt,
    input  logic                  start,
    input  logic [NSINK*8-1:0]    bp_period,
    input  logic [NSINK*8-1:0]    bp_thresh,
    output logic [DW-1:0]         src_data_o,
    output logic                  src_valid_o,
    input  logic                  src_ready_i,
    input  logic [NSINK*DW-1:0]   snk_data_i,
    input  logic [NSINK-1:0]      snk_valid_i,
    output logic [NSINK-1:0]      snk_ready_o,
    output logic [NSINK*CW-1:0]   snk_count_o,
    output logic [NSINK*DW-1:0]   snk_xor_o,
    output logic [AW-1:0]         sent_o,
    output logic [2:0]            state_o,
    output logic                  done_o,
    output logic                  deadlock_o
);

    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW  = $clog2(WIN);
    localparam int DRW = $clog2(DRAIN + 1);
    localparam int SW  = CW + $clog2(NSINK + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_DRAIN    = 3'd2,
        S_DONE     = 3'd3,
        S_DEADLOCK = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    count_q, count_d;
    logic [AW-1:0]    sent_q, sent_d;
    logic [DRW-1:0]   drain_q, drain_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic [AW-1:0]    snap_sent_q, snap_sent_d;
    logic [SW-1:0]    snap_sum_q, snap_sum_d;
    logic             done_q, done_d;
    logic             dead_q, dead_d;
    logic [7:0]       phase_q [NSINK];
    logic [7:0]       phase_d [NSINK];
    logic [CW-1:0]    cnt_q [NSINK];
    logic [CW-1:0]    cnt_d [NSINK];
    logic [DW-1:0]    xor_q [NSINK];
    logic [DW-1:0]    xor_d [NSINK];

    logic [DW-1:0]    mem_q [DEPTH];

    logic             active;
    logic             src_valid;
    logic             src_fire;
    logic [NSINK-1:0] snk_ready;
    logic [NSINK-1:0] snk_fire;
    logic [SW-1:0]    sum;
    logic [AW-1:0]    cnt_sat;
    logic [IW-1:0]    rd_idx;
    logic             wd_last;
    logic             stalled;

    // NOTE: the packet memory has no reset; its contents are only meaningful after software loads them.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && cfg_we && cfg_addr < AW'(DEPTH)) begin
            mem_q[cfg_addr[IW-1:0]] <= cfg_data;
        end
    end

    assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign src_valid = (state_q == S_RUN) && (sent_q < count_q);
    assign src_fire  = src_valid && src_ready_i;
    assign cnt_sat   = (pkt_cnt > AW'(DEPTH)) ? AW'(DEPTH) : pkt_cnt;
    assign rd_idx    = (sent_q < AW'(DEPTH)) ? sent_q[IW-1:0] : '0;
    assign wd_last   = (wd_q == WW'(WIN - 1));

    // NOTE: every always_comb output gets a default before any branch so no latch can be inferred.
    always_comb begin
        snk_ready = '0;
        snk_fire  = '0;
        sum       = '0;
        for (int i = 0; i < NSINK; i++) begin
            snk_ready[i] = active && (phase_q[i] > bp_thresh[i*8 +: 8]);
            snk_fire[i]  = snk_ready[i] && snk_valid_i[i];
            sum          = sum + SW'(cnt_q[i]);
        end
    end

    // Any handshake on either side during the window counts as forward progress.
    assign stalled = (sent_q < count_q) && (sent_q == snap_sent_q) && (sum == snap_sum_q)
                     && !src_fire && !(|snk_fire);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sent_d      = sent_q;
        drain_d     = drain_q;
        wd_d        = wd_q;
        snap_sent_d = snap_sent_q;
        snap_sum_d  = snap_sum_q;
        done_d      = done_q;
        dead_d      = dead_q;
        for (int i = 0; i < NSINK; i++) begin
            phase_d[i] = '0;
            cnt_d[i]   = cnt_q[i];
            xor_d[i]   = xor_q[i];
            if (active) begin
                phase_d[i] = (phase_q[i] >= bp_period[i*8 +: 8]) ? 8'd0 : phase_q[i] + 8'd1;
            end
            if (snk_fire[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
                xor_d[i] = xor_q[i] ^ snk_data_i[i*DW +: DW];
            end
        end
        if (src_fire) begin
            sent_d = sent_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d = cnt_sat;
                    sent_d  = '0;
                    wd_d    = '0;
                    drain_d = '0;
                    done_d  = 1'b0;
                    dead_d  = 1'b0;
                    for (int i = 0; i < NSINK; i++) begin
                        cnt_d[i] = '0;
                        xor_d[i] = '0;
                    end
                    state_d = (cnt_sat == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                wd_d = wd_last ? '0 : wd_q + 1'b1;
                if (wd_q == '0) begin
                    snap_sent_d = sent_q;
                    snap_sum_d  = sum;
                end
                if (src_fire && (sent_q + 1'b1 == count_q)) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else if (wd_last && stalled) begin
                    state_d = S_DEADLOCK;
                    dead_d  = 1'b1;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DRW'(DRAIN - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE, S_DEADLOCK: begin
                if (start) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                    dead_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            sent_q      <= '0;
            drain_q     <= '0;
            wd_q        <= '0;
            snap_sent_q <= '0;
            snap_sum_q  <= '0;
            done_q      <= 1'b0;
            dead_q      <= 1'b0;
            for (int i = 0; i < NSINK; i++) begin
                phase_q[i] <= '0;
                cnt_q[i]   <= '0;
                xor_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sent_q      <= sent_d;
            drain_q     <= drain_d;
            wd_q        <= wd_d;
            snap_sent_q <= snap_sent_d;
            snap_sum_q  <= snap_sum_d;
            done_q      <= done_d;
            dead_q      <= dead_d;
            for (int i = 0; i < NSINK; i++) begin
                phase_q[i] <= phase_d[i];
                cnt_q[i]   <= cnt_d[i];
                xor_q[i]   <= xor_d[i];
            end
        end
    end

    always_comb begin
        snk_count_o = '0;
        snk_xor_o   = '0;
        for (int i = 0; i < NSINK; i++) begin
            snk_count_o[i*CW +: CW] = cnt_q[i];
            snk_xor_o[i*DW +: DW]   = xor_q[i];
        end
    end

    assign snk_ready_o = snk_ready;
    assign src_valid_o = src_valid;
    assign src_data_o  = mem_q[rd_idx];
    assign sent_o      = sent_q;
    assign state_o     = state_q;
    assign done_o      = done_q;
    assign deadlock_o  = dead_q;

endmodule
